spi_slave_stream: RTL and testbench

SPI_SLAVE_STREAM -- requirements
Module: spi_slave_stream

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_edge_sync.sv | 33 +++
 rtl/spi_slave_stream.sv | 226 ++++++++++++++++++++++
 tb/tb_spi_slave_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and edge-selection helpers for the SPI slave stream block.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam logic EDGE_RISE = 1'b1;
  localparam logic EDGE_FALL = 1'b0;

  // Sample edge is the rising sclk edge exactly when CPOL and CPHA agree.
  function automatic logic sample_is_rise(input logic cpol, input logic cpha);
    return (cpol == cpha) ? EDGE_RISE : EDGE_FALL;
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer for one asynchronous input, with one-cycle rise/fall pulses
// derived from the synchronized level. RST_VAL is the idle level held in reset.
module spi_edge_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
      prev_r <= RST_VAL;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign rise = sync_r & ~prev_r;
  assign fall = ~sync_r & prev_r;

endmodule

// File: rtl/spi_slave_stream.sv
// SPI slave with valid/ready word streams on both directions.
// Define SPI_SLAVE_STREAM_ERR_EN to build the sticky underrun/overrun flags.
module spi_slave_stream
  import spi_pkg::*;
#(
  parameter logic                CPOL      = 1'b1,
  parameter logic                CPHA      = 1'b1,
  parameter int                  DATA_WDT  = 8,
  parameter logic                MSB_FIRST = 1'b1,
  parameter logic [DATA_WDT-1:0] FILL_WORD = {DATA_WDT{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ssel,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  output logic                misoOe,
  input  logic [DATA_WDT-1:0] txData,
  input  logic                txValid,
  output logic                txReady,
  output logic [DATA_WDT-1:0] rxData,
  output logic                rxValid,
  input  logic                rxReady,
  output logic                errUnderrun,
  output logic                errOverrun,
  input  logic                errClr
);

  localparam int             CW          = $clog2(DATA_WDT);
  localparam logic [CW-1:0]  CNT_LAST    = CW'(DATA_WDT - 1);
  localparam logic [CW-1:0]  CNT_ZERO    = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE     = CW'(1);
  localparam logic           SAMPLE_RISE = sample_is_rise(CPOL, CPHA);

  logic                rst_meta_r;
  logic                rst_n_r;
  logic                mosi_meta_r;
  logic                mosi_r;
  logic                ssel_rise_s;
  logic                ssel_fall_s;
  logic                sclk_rise_s;
  logic                sclk_fall_s;
  spi_state_e          state_r;
  spi_state_e          state_s;
  logic                activate_s;
  logic                deactivate_s;
  logic                sample_s;
  logic                shift_s;
  logic                tx_load_s;
  logic                tx_shift_s;
  logic [DATA_WDT-1:0] tx_sr_r;
  logic [DATA_WDT-1:0] rx_sr_r;
  logic [CW-1:0]       tx_cnt_r;
  logic [CW-1:0]       rx_cnt_r;
  logic                tx_first_r;
  logic                word_done_r;
  logic                under_set_s;
  logic                over_set_s;

  // Reset asserts asynchronously but is released on a clk edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_meta_r <= 1'b0;
      rst_n_r    <= 1'b0;
    end else begin
      rst_meta_r <= 1'b1;
      rst_n_r    <= rst_meta_r;
    end
  end

  spi_edge_sync #(.RST_VAL(1'b1)) u_ssel_sync (
    .clk(clk), .reset(rst_n_r), .din(ssel), .rise(ssel_rise_s), .fall(ssel_fall_s)
  );

  spi_edge_sync #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .reset(rst_n_r), .din(sclk), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  // mosi takes the same two-flop path so it is aligned with the sclk edge pulses
  always_ff @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      mosi_meta_r <= 1'b0;
      mosi_r      <= 1'b0;
    end else begin
      mosi_meta_r <= mosi;
      mosi_r      <= mosi_meta_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state and per-cycle SPI events; edges are ignored on the deselect cycle
  always_comb begin
    state_s      = state_r;
    activate_s   = 1'b0;
    deactivate_s = 1'b0;
    sample_s     = 1'b0;
    shift_s      = 1'b0;
    tx_load_s    = 1'b0;
    tx_shift_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (ssel_fall_s) begin
          state_s    = ACTIVE;
          activate_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ssel_rise_s) begin
          state_s      = IDLE;
          deactivate_s = 1'b1;
        end else begin
          sample_s = SAMPLE_RISE ? sclk_rise_s : sclk_fall_s;
          shift_s  = SAMPLE_RISE ? sclk_fall_s : sclk_rise_s;
        end
      end
      default: state_s = IDLE;
    endcase
    // CPHA=1 reloads on the first shift edge of a word; the very first word is
    // already loaded at select time, so that edge only clears tx_first_r
    if (CPHA == 1'b0) begin
      tx_load_s  = activate_s | (shift_s & (tx_cnt_r == CNT_LAST));
      tx_shift_s = shift_s & (tx_cnt_r != CNT_LAST);
    end else begin
      tx_load_s  = activate_s | (shift_s & (tx_cnt_r == CNT_ZERO) & ~tx_first_r);
      tx_shift_s = shift_s & (tx_cnt_r != CNT_ZERO);
    end
  end

  assign misoOe      = (state_r == ACTIVE);
  assign miso        = MSB_FIRST ? tx_sr_r[DATA_WDT-1] : tx_sr_r[0];
  assign under_set_s = tx_load_s & ~txValid;
  assign over_set_s  = word_done_r & rxValid & ~rxReady;

  // Transmit shift register, shift-edge counter and load handshake
  always_ff @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      tx_sr_r    <= {DATA_WDT{1'b0}};
      tx_cnt_r   <= CNT_ZERO;
      tx_first_r <= 1'b0;
      txReady    <= 1'b0;
    end else begin
      txReady <= tx_load_s & txValid;
      if (tx_load_s) begin
        tx_sr_r <= txValid ? txData : FILL_WORD;
      end else if (deactivate_s) begin
        tx_sr_r <= {DATA_WDT{1'b0}};
      end else if (tx_shift_s) begin
        tx_sr_r <= MSB_FIRST ? {tx_sr_r[DATA_WDT-2:0], 1'b0} : {1'b0, tx_sr_r[DATA_WDT-1:1]};
      end
      if (activate_s || deactivate_s) begin
        tx_cnt_r <= CNT_ZERO;
      end else if (shift_s) begin
        tx_cnt_r <= (tx_cnt_r == CNT_LAST) ? CNT_ZERO : tx_cnt_r + CNT_ONE;
      end
      if (activate_s) begin
        tx_first_r <= 1'b1;
      end else if (shift_s || deactivate_s) begin
        tx_first_r <= 1'b0;
      end
    end
  end

  // Receive shift register and word delivery; a full word is handed over one clk later
  always_ff @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      rx_sr_r     <= {DATA_WDT{1'b0}};
      rx_cnt_r    <= CNT_ZERO;
      word_done_r <= 1'b0;
      rxData      <= {DATA_WDT{1'b0}};
      rxValid     <= 1'b0;
    end else begin
      word_done_r <= sample_s & (rx_cnt_r == CNT_LAST);
      if (activate_s || deactivate_s) begin
        rx_sr_r  <= {DATA_WDT{1'b0}};
        rx_cnt_r <= CNT_ZERO;
      end else if (sample_s) begin
        rx_sr_r  <= MSB_FIRST ? {rx_sr_r[DATA_WDT-2:0], mosi_r} : {mosi_r, rx_sr_r[DATA_WDT-1:1]};
        rx_cnt_r <= (rx_cnt_r == CNT_LAST) ? CNT_ZERO : rx_cnt_r + CNT_ONE;
      end
      if (word_done_r && (!rxValid || rxReady)) begin
        rxData  <= rx_sr_r;
        rxValid <= 1'b1;
      end else if (rxValid && rxReady) begin
        rxValid <= 1'b0;
      end
    end
  end

`ifdef SPI_SLAVE_STREAM_ERR_EN
  // Sticky error flags; a new error event takes priority over errClr
  always_ff @(posedge clk or negedge rst_n_r) begin
    if (!rst_n_r) begin
      errUnderrun <= 1'b0;
      errOverrun  <= 1'b0;
    end else begin
      if (under_set_s) begin
        errUnderrun <= 1'b1;
      end else if (errClr) begin
        errUnderrun <= 1'b0;
      end
      if (over_set_s) begin
        errOverrun <= 1'b1;
      end else if (errClr) begin
        errOverrun <= 1'b0;
      end
    end
  end
`else
  logic unused_err;
  assign unused_err  = ^{errClr, under_set_s, over_set_s};
  assign errUnderrun = 1'b0;
  assign errOverrun  = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_stream.sv
// Directed bench: three slaves (mode 3 8-bit MSB, mode 0 8-bit MSB, mode 3 16-bit LSB)
// driven by a behavioural SPI master task.
module tb_spi_slave_stream;

`ifdef SPI_SLAVE_STREAM_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  localparam logic [2:0] CPOL_V = 3'b101;
  localparam logic [2:0] CPHA_V = 3'b101;
  localparam logic [2:0] MSB_V  = 3'b011;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic ssel [3];
  logic sclk [3];
  logic mosi [3];
  logic miso [3];
  logic miso_oe [3];
  logic tx_valid [3];
  logic tx_ready [3];
  logic rx_valid [3];
  logic rx_ready [3];
  logic err_u [3];
  logic err_o [3];
  logic err_clr [3];
  logic [7:0]  txd0, txd1, rxd0, rxd1;
  logic [15:0] txd2, rxd2;

  int n_chk  = 0;
  int n_pass = 0;
  int txr_cnt0 = 0;

  spi_slave_stream #(.CPOL(1'b1), .CPHA(1'b1), .DATA_WDT(8), .MSB_FIRST(1'b1)) u_m3 (
    .clk(clk), .reset(reset), .ssel(ssel[0]), .sclk(sclk[0]), .mosi(mosi[0]),
    .miso(miso[0]), .misoOe(miso_oe[0]), .txData(txd0), .txValid(tx_valid[0]),
    .txReady(tx_ready[0]), .rxData(rxd0), .rxValid(rx_valid[0]), .rxReady(rx_ready[0]),
    .errUnderrun(err_u[0]), .errOverrun(err_o[0]), .errClr(err_clr[0]));

  spi_slave_stream #(.CPOL(1'b0), .CPHA(1'b0), .DATA_WDT(8), .MSB_FIRST(1'b1)) u_m0 (
    .clk(clk), .reset(reset), .ssel(ssel[1]), .sclk(sclk[1]), .mosi(mosi[1]),
    .miso(miso[1]), .misoOe(miso_oe[1]), .txData(txd1), .txValid(tx_valid[1]),
    .txReady(tx_ready[1]), .rxData(rxd1), .rxValid(rx_valid[1]), .rxReady(rx_ready[1]),
    .errUnderrun(err_u[1]), .errOverrun(err_o[1]), .errClr(err_clr[1]));

  spi_slave_stream #(.CPOL(1'b1), .CPHA(1'b1), .DATA_WDT(16), .MSB_FIRST(1'b0)) u_w16 (
    .clk(clk), .reset(reset), .ssel(ssel[2]), .sclk(sclk[2]), .mosi(mosi[2]),
    .miso(miso[2]), .misoOe(miso_oe[2]), .txData(txd2), .txValid(tx_valid[2]),
    .txReady(tx_ready[2]), .rxData(rxd2), .rxValid(rx_valid[2]), .rxReady(rx_ready[2]),
    .errUnderrun(err_u[2]), .errOverrun(err_o[2]), .errClr(err_clr[2]));

  // Count cycles in which slave 0 raises txReady
  always @(negedge clk) begin
    if (tx_ready[0]) txr_cnt0 <= txr_cnt0 + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic sel(input int d);
    @(negedge clk) ssel[d] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic desel(input int d);
    repeat (8) @(negedge clk);
    ssel[d] = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  // Clock n bits through slave d; sclk half period is 8 clk cycles
  task automatic xfer(input int d, input int n, input logic [31:0] mo, output logic [31:0] mi);
    int bi;
    mi = 32'h0;
    for (int i = 0; i < n; i++) begin
      bi = MSB_V[d] ? (n - 1 - i) : i;
      if (!CPHA_V[d]) begin
        mosi[d] = mo[bi];
        repeat (8) @(negedge clk);
        sclk[d] = ~CPOL_V[d];
        mi[bi]  = miso[d];
        repeat (8) @(negedge clk);
        sclk[d] = CPOL_V[d];
      end else begin
        repeat (8) @(negedge clk);
        sclk[d] = ~CPOL_V[d];
        mosi[d] = mo[bi];
        repeat (8) @(negedge clk);
        sclk[d] = CPOL_V[d];
        mi[bi]  = miso[d];
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_txr(input int d, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tx_ready[d]) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rxv(input int d, output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (rx_valid[d]) begin ok = 1'b1; break; end
    end
  endtask

  logic [31:0] mi;
  logic [7:0]  cap0, cap1;
  logic        ok0, ok1, ok2, ok3;
  int          txr_snap;

  initial begin
    for (int d = 0; d < 3; d++) begin
      ssel[d] = 1'b1; sclk[d] = CPOL_V[d]; mosi[d] = 1'b0;
      tx_valid[d] = 1'b1; rx_ready[d] = 1'b0; err_clr[d] = 1'b0;
    end
    rx_ready[1] = 1'b1;
    txd0 = 8'h3C; txd1 = 8'h5A; txd2 = 16'hBEEF;
    cap0 = 8'h00; cap1 = 8'h00;

    repeat (5) @(negedge clk);
    check_eq("rst_miso_oe", miso_oe[0], 1'b0);
    check_eq("rst_miso", miso[0], 1'b0);
    check_eq("rst_rx_valid", rx_valid[0], 1'b0);
    check_eq("rst_rx_data", rxd0, 8'h00);
    check_eq("rst_tx_ready", tx_ready[0], 1'b0);
    check_eq("rst_err_u", err_u[0], 1'b0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Mode 3: A5 in, 3C out
    txr_snap = txr_cnt0;
    sel(0);
    check_eq("m3_miso_oe", miso_oe[0], 1'b1);
    xfer(0, 8, 32'hA5, mi);
    desel(0);
    check_eq("m3_rx_data", rxd0, 8'hA5);
    check_eq("m3_rx_valid", rx_valid[0], 1'b1);
    check_eq("m3_master_rx", mi, 32'h3C);
    check_eq("m3_tx_ready_cnt", txr_cnt0 - txr_snap, 1);
    check_eq("m3_idle_miso_oe", miso_oe[0], 1'b0);

    // Mode 0: two back-to-back words, second tx word loaded at 8th trailing edge
    fork
      begin sel(1); xfer(1, 16, 32'h1234, mi); desel(1); end
      begin wait_txr(1, ok0); txd1 = 8'h96; wait_txr(1, ok1); txd1 = 8'h0F; end
      begin wait_rxv(1, ok2); cap0 = rxd1; wait_rxv(1, ok3); cap1 = rxd1; end
    join
    check_eq("m0_txr_first", ok0, 1'b1);
    check_eq("m0_txr_second", ok1, 1'b1);
    check_eq("m0_rxv_first", ok2, 1'b1);
    check_eq("m0_rxv_second", ok3, 1'b1);
    check_eq("m0_word0", cap0, 8'h12);
    check_eq("m0_word1", cap1, 8'h34);
    check_eq("m0_master_rx", mi, 32'h5A96);

    // Underrun: nothing valid to send
    rx_ready[0] = 1'b1;
    tx_valid[0] = 1'b0;
    sel(0);
    xfer(0, 8, 32'h00, mi);
    desel(0);
    tx_valid[0] = 1'b1;
    check_eq("ur_master_rx", mi, 32'hFF);
    check_eq("ur_flag", err_u[0], ERR);
    check_eq("ur_rx_consumed", rx_valid[0], 1'b0);
    @(negedge clk) err_clr[0] = 1'b1;
    @(negedge clk) err_clr[0] = 1'b0;
    @(negedge clk);
    check_eq("ur_cleared", err_u[0], 1'b0);

    // Overrun: consumer stalled across two words
    rx_ready[0] = 1'b0;
    sel(0);
    xfer(0, 16, 32'h55AA, mi);
    desel(0);
    check_eq("or_rx_data", rxd0, 8'h55);
    check_eq("or_rx_valid", rx_valid[0], 1'b1);
    check_eq("or_flag", err_o[0], ERR);
    @(negedge clk) begin rx_ready[0] = 1'b1; err_clr[0] = 1'b1; end
    @(negedge clk) begin rx_ready[0] = 1'b0; err_clr[0] = 1'b0; end
    @(negedge clk);
    check_eq("or_rx_drained", rx_valid[0], 1'b0);
    check_eq("or_cleared", err_o[0], 1'b0);

    // Deselect after 5 bits, then a clean word
    sel(0);
    xfer(0, 5, 32'hF8, mi);
    @(negedge clk) ssel[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("ab_miso_oe", miso_oe[0], 1'b0);
    repeat (10) @(negedge clk);
    check_eq("ab_no_rx_valid", rx_valid[0], 1'b0);
    sel(0);
    xfer(0, 8, 32'h81, mi);
    desel(0);
    check_eq("ab_next_rx", rxd0, 8'h81);
    check_eq("ab_next_valid", rx_valid[0], 1'b1);

    // 16-bit LSB-first
    sel(2);
    xfer(2, 16, 32'h1234, mi);
    desel(2);
    check_eq("w16_rx_data", rxd2, 16'h1234);
    check_eq("w16_rx_valid", rx_valid[2], 1'b1);
    check_eq("w16_master_rx", mi, 32'hBEEF);

    // Reset mid-word takes effect without a clock edge
    sel(2);
    xfer(2, 6, 32'h3F, mi);
    check_eq("mid_miso_oe", miso_oe[2], 1'b1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_miso_oe", miso_oe[2], 1'b0);
    check_eq("mid_rst_miso", miso[2], 1'b0);
    check_eq("mid_rst_rx_valid", rx_valid[2], 1'b0);
    check_eq("mid_rst_rx_data", rxd2, 16'h0000);
    check_eq("mid_rst_tx_ready", tx_ready[2], 1'b0);
    check_eq("mid_rst_rx_data0", rxd0, 8'h00);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    ssel[2] = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
